coincidence_counter: RTL

- Consumes the single-cycle shaped pulses from two pulse-shaper instances: channel A (signal detector) and channel B (reference/herald).
- Over a programmable gate period, it counts singles on A, singles on B, and A–B coincidences inside a cycle window.
- At gate end it presents the three counts through a valid/ready handshake to the readout/host-interface stage.
- Sits directly downstream of the shapers in the time-correlation path and runs in the same 500 MHz clock domain.

---
 rtl/coincidence_counter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/coincidence_counter.sv
// Gated singles and A-B coincidence counter for two shaped pulse channels, with valid/ready readout.
// Define COINC_ACCIDENTAL_EN to build the delayed-B accidental-coincidence channel (count_acc).
module coincidence_counter #(
    parameter int COUNT_W = 16,
    parameter int WINDOW  = 4,
    parameter int GATE_W  = 32
`ifdef COINC_ACCIDENTAL_EN
    ,
    parameter int ACC_DELAY = 50
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pulse_a,
    input  logic               pulse_b,
    input  logic [GATE_W-1:0]  gate_len,
    input  logic               start,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] count_a,
    output logic [COUNT_W-1:0] count_b,
    output logic [COUNT_W-1:0] count_ab,
    output logic               sat
`ifdef COINC_ACCIDENTAL_EN
    ,
    output logic [COUNT_W-1:0] count_acc
`endif
);

    // Ages run 0..WINDOW while a pulse is waiting for a partner; WINDOW+1 means no pulse waiting.
    localparam int AGE_W = $clog2(WINDOW + 2);
    localparam logic [AGE_W-1:0]   AGE_INV = AGE_W'(WINDOW + 1);
    localparam logic [AGE_W-1:0]   AGE_WIN = AGE_W'(WINDOW);
    localparam logic [AGE_W-1:0]   AGE_ZERO = {AGE_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        REPORT = 2'd2
    } state_t;

    typedef struct packed {
        logic             hit;
        logic [AGE_W-1:0] age_a;
        logic [AGE_W-1:0] age_b;
    } track_t;

    function automatic logic [AGE_W-1:0] age_step(input logic [AGE_W-1:0] age);
        if (age >= AGE_INV) begin
            return AGE_INV;
        end else begin
            return age + AGE_W'(1);
        end
    endfunction

    // One tracker step: ages become "cycles since the waiting pulse" for this cycle, then
    // a match consumes both sides so each pulse takes part in at most one coincidence.
    function automatic track_t track(input logic pa, input logic pb,
                                     input logic [AGE_W-1:0] age_a,
                                     input logic [AGE_W-1:0] age_b);
        track_t res;
        res.hit   = 1'b0;
        res.age_a = age_step(age_a);
        res.age_b = age_step(age_b);
        if (pa && pb) begin
            res.hit   = 1'b1;
            res.age_a = AGE_INV;
            res.age_b = AGE_INV;
        end else if (pa) begin
            if (res.age_b <= AGE_WIN) begin
                res.hit   = 1'b1;
                res.age_a = AGE_INV;
                res.age_b = AGE_INV;
            end else begin
                res.age_a = AGE_ZERO;
            end
        end else if (pb) begin
            if (res.age_a <= AGE_WIN) begin
                res.hit   = 1'b1;
                res.age_a = AGE_INV;
                res.age_b = AGE_INV;
            end else begin
                res.age_b = AGE_ZERO;
            end
        end else begin
            res.hit = 1'b0;
        end
        return res;
    endfunction

    // Returns {overflow, next value}; an increment at max is dropped and flagged.
    function automatic logic [COUNT_W:0] cnt_step(input logic [COUNT_W-1:0] cnt, input logic inc);
        if (!inc) begin
            return {1'b0, cnt};
        end else if (cnt == CNT_MAX) begin
            return {1'b1, cnt};
        end else begin
            return {1'b0, cnt + COUNT_W'(1)};
        end
    endfunction

    state_t              state_r, state_next_s;
    logic [GATE_W-1:0]   gate_cnt_r;
    logic [COUNT_W-1:0]  cnt_a_r, cnt_b_r, cnt_ab_r;
    logic                sat_r;
    logic [AGE_W-1:0]    age_a_r, age_b_r;
    track_t              trk_s;
    logic [COUNT_W:0]    step_a_s, step_b_s, step_ab_s;
    logic                gate_last_s, gate_start_s, sat_next_s, acc_sat_s;

    assign gate_last_s  = (state_r == GATE) && (gate_cnt_r == GATE_W'(1));
    assign gate_start_s = (state_r == IDLE) && start;

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (start) state_next_s = GATE;      else state_next_s = IDLE;
            GATE:    if (gate_last_s) state_next_s = REPORT; else state_next_s = GATE;
            REPORT:  if (out_ready) state_next_s = IDLE;  else state_next_s = REPORT;
            default: state_next_s = IDLE;
        endcase
    end

    // State register with registered busy/out_valid flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            busy      <= (state_next_s != IDLE);
            out_valid <= (state_next_s == REPORT);
        end
    end

    // Per-cycle coincidence and singles increments.
    always_comb begin
        trk_s      = track(pulse_a, pulse_b, age_a_r, age_b_r);
        step_a_s   = cnt_step(cnt_a_r, pulse_a);
        step_b_s   = cnt_step(cnt_b_r, pulse_b);
        step_ab_s  = cnt_step(cnt_ab_r, trk_s.hit);
        sat_next_s = sat_r | step_a_s[COUNT_W] | step_b_s[COUNT_W] | step_ab_s[COUNT_W] | acc_sat_s;
    end

    // Gate counter, running counters and the result registers presented to the reader.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt_r <= {GATE_W{1'b0}};
            cnt_a_r    <= CNT_ZERO;
            cnt_b_r    <= CNT_ZERO;
            cnt_ab_r   <= CNT_ZERO;
            sat_r      <= 1'b0;
            age_a_r    <= AGE_INV;
            age_b_r    <= AGE_INV;
            count_a    <= CNT_ZERO;
            count_b    <= CNT_ZERO;
            count_ab   <= CNT_ZERO;
            sat        <= 1'b0;
        end else if (gate_start_s) begin
            gate_cnt_r <= (gate_len == {GATE_W{1'b0}}) ? GATE_W'(1) : gate_len;
            cnt_a_r    <= CNT_ZERO;
            cnt_b_r    <= CNT_ZERO;
            cnt_ab_r   <= CNT_ZERO;
            sat_r      <= 1'b0;
            age_a_r    <= AGE_INV;
            age_b_r    <= AGE_INV;
        end else if (state_r == GATE) begin
            gate_cnt_r <= gate_cnt_r - GATE_W'(1);
            cnt_a_r    <= step_a_s[COUNT_W-1:0];
            cnt_b_r    <= step_b_s[COUNT_W-1:0];
            cnt_ab_r   <= step_ab_s[COUNT_W-1:0];
            sat_r      <= sat_next_s;
            age_a_r    <= trk_s.age_a;
            age_b_r    <= trk_s.age_b;
            if (gate_last_s) begin
                count_a  <= step_a_s[COUNT_W-1:0];
                count_b  <= step_b_s[COUNT_W-1:0];
                count_ab <= step_ab_s[COUNT_W-1:0];
                sat      <= sat_next_s;
            end
        end
    end

`ifdef COINC_ACCIDENTAL_EN
    logic [ACC_DELAY-1:0] dly_r;
    logic [AGE_W-1:0]     acc_age_a_r, acc_age_b_r;
    logic [COUNT_W-1:0]   cnt_acc_r;
    track_t               acc_trk_s;
    logic [COUNT_W:0]     step_acc_s;

    // Accidental tracker: A against B delayed by ACC_DELAY counted cycles.
    always_comb begin
        acc_trk_s  = track(pulse_a, dly_r[ACC_DELAY-1], acc_age_a_r, acc_age_b_r);
        step_acc_s = cnt_step(cnt_acc_r, acc_trk_s.hit);
        acc_sat_s  = step_acc_s[COUNT_W];
    end

    // Delay line, accidental counter and its result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_r       <= {ACC_DELAY{1'b0}};
            acc_age_a_r <= AGE_INV;
            acc_age_b_r <= AGE_INV;
            cnt_acc_r   <= CNT_ZERO;
            count_acc   <= CNT_ZERO;
        end else if (gate_start_s) begin
            dly_r       <= {ACC_DELAY{1'b0}};
            acc_age_a_r <= AGE_INV;
            acc_age_b_r <= AGE_INV;
            cnt_acc_r   <= CNT_ZERO;
        end else if (state_r == GATE) begin
            dly_r       <= (dly_r << 1) | ACC_DELAY'(pulse_b);
            acc_age_a_r <= acc_trk_s.age_a;
            acc_age_b_r <= acc_trk_s.age_b;
            cnt_acc_r   <= step_acc_s[COUNT_W-1:0];
            if (gate_last_s) begin
                count_acc <= step_acc_s[COUNT_W-1:0];
            end
        end
    end
`else
    assign acc_sat_s = 1'b0;
`endif

endmodule
